i2c_cmd_arbiter: RTL and testbench

Shares the single 24-bit I2C sender (codec configuration path) between N_REQ independent command sources, e.g. the power-on register initializer and runtime volume/mode control. Arbitration is round-robin. The block owns the sender's start/data inputs, tracks each transfer to completion via the sender's done level, and acknowledges the winning requester. A watchdog aborts a transfer that never completes, so one hung transfer cannot lock the bus.

---
 rtl/i2c_pkg.sv | 9 +
 rtl/rr_pick.sv | 17 +
 rtl/i2c_cmd_arbiter.sv | 84 ++++++++
 tb/tb_i2c_cmd_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and helpers for the codec configuration command path
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK} state_t;
  localparam int DATA_W_DEF = 24;
  localparam logic [7:0] CODEC_ADDR = 8'h34;
  function automatic logic [23:0] make_cmd(input logic [6:0] reg_num, input logic [8:0] value);
    return {CODEC_ADDR, reg_num, value};
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after the pointer, wrapping around
module rr_pick #(
  parameter int N = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) idx = PW'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one I2C command sender between requesters,
// with a per-transfer watchdog so a hung sender cannot lock out the other sources.
module i2c_cmd_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*DATA_W-1:0]    i_dat,
  output logic [N_REQ-1:0]           o_ack,
  output logic                       o_err,
  output logic                       o_busy,
  output logic [$clog2(N_REQ)-1:0]   o_owner,
  output logic                       o_start,
  output logic [DATA_W-1:0]          o_dat,
  input  logic                       i_done
);
  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  state_t state;
  logic [PW-1:0] ptr, pick_idx;
  logic pick_valid;
  logic [TW-1:0] timer;
  logic [N_REQ-1:0] owner_hot;
  logic [DATA_W-1:0] pick_dat;
  rr_pick #(.N(N_REQ)) u_pick (.req(i_req), .ptr(ptr), .valid(pick_valid), .idx(pick_idx));
  assign owner_hot = N_REQ'(1) << o_owner;
  assign pick_dat = i_dat[pick_idx*DATA_W +: DATA_W];
  // a sender that never drops i_done is assumed already running after two cycles
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      o_ack <= '0;
      o_err <= 1'b0;
      o_busy <= 1'b0;
      o_owner <= '0;
      o_start <= 1'b0;
      o_dat <= '0;
      ptr <= '0;
      timer <= '0;
    end else begin
      o_start <= 1'b0;
      o_ack <= '0;
      o_err <= 1'b0;
      unique case (state)
        IDLE: if (pick_valid && i_done) begin
          state <= ISSUE;
          o_owner <= pick_idx;
          o_dat <= pick_dat;
          o_start <= 1'b1;
          o_busy <= 1'b1;
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          timer <= timer + 1'b1;
          if (timer == T_LAST) begin
            state <= ACK;
            o_ack <= owner_hot;
            o_err <= 1'b1;
          end else if (state == WAIT_BUSY && (!i_done || timer == TW'(1))) begin
            state <= WAIT_DONE;
          end else if (state == WAIT_DONE && i_done) begin
            state <= ACK;
            o_ack <= owner_hot;
          end
        end
        ACK: begin
          state <= IDLE;
          o_busy <= 1'b0;
          ptr <= (o_owner == PW'(N_REQ - 1)) ? '0 : o_owner + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: directed and random checks of the arbiter against a
// behavioural sender and a round-robin reference model.
module tb_i2c_cmd_arbiter;
  import i2c_pkg::*;
  localparam int N = 2, W = 24, TO = 64;
  typedef struct {int t; int own; logic [W-1:0] d; int exp_own; logic [W-1:0] exp_d;} st_ev;
  typedef struct {int t; logic [N-1:0] a; logic e; int exp_own;} ack_ev;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] dat = '0;
  logic done;
  logic [N-1:0] ack;
  logic err, busy, start;
  logic [$clog2(N)-1:0] owner;
  logic [W-1:0] odat;
  int n_chk = 0, n_fail = 0;
  int t = 0, rise_t = 0, m_ptr = 0, m_own = 0, busy_len = 30, cnt = 0;
  bit hang = 0, kick = 0;
  logic [N-1:0] rereq = '0, raise = '0, s_ack = '0, edge_req = '0;
  logic [N*W-1:0] edge_dat = '0;
  logic s_err = 0, s_busy = 0, s_start = 0, s_done = 1;
  logic [$clog2(N)-1:0] s_own = '0;
  logic [W-1:0] s_dat = '0;
  st_ev sq[$];
  ack_ev aq[$];
  i2c_cmd_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_dat(dat), .o_ack(ack), .o_err(err),
    .o_busy(busy), .o_owner(owner), .o_start(start), .o_dat(odat), .i_done(done));
  always #5 clk = ~clk;
  // sender: drops done on start, raises it busy_len cycles later unless hung
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b1;
      cnt <= 0;
    end else if (start) begin
      done <= 1'b0;
      cnt <= busy_len;
    end else if (!done && (kick || (!hang && cnt <= 1))) done <= 1'b1;
    else if (!done) cnt <= cnt - 1;
  end
  function automatic int m_pick(input logic [N-1:0] r, input int p);
    for (int o = 0; o < N; o++) if (r[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction
  task automatic tick();
    @(posedge clk);
    edge_req = req;
    edge_dat = dat;
    #1;
    for (int k = 0; k < N; k++) begin
      if (raise[k]) begin req[k] = 1'b1; raise[k] = 1'b0; end
      if (s_ack[k]) begin req[k] = 1'b0; raise[k] = rereq[k]; end
    end
    @(negedge clk);
    t++;
    s_ack = ack; s_err = err; s_busy = busy; s_start = start; s_own = owner; s_dat = odat;
    if (done && !s_done) rise_t = t;
    s_done = done;
    if (s_start) begin
      m_own = m_pick(edge_req, m_ptr);
      sq.push_back('{t, int'(s_own), s_dat, m_own, (m_own < 0) ? '0 : edge_dat[m_own*W +: W]});
    end
    if (|s_ack) begin
      aq.push_back('{t, s_ack, s_err, m_own});
      m_ptr = (m_own + 1) % N;
    end
  endtask
  task automatic wait_start(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (s_start) begin at = t; return; end
    end
  endtask
  task automatic wait_ack(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (|s_ack) begin at = t; return; end
    end
  endtask
  task automatic reset_dut();
    rst = 1'b0;
    req = '0; dat = '0; rereq = '0; raise = '0; hang = 0; kick = 0; busy_len = 30;
    repeat (2) tick();
    sq.delete(); aq.delete();
    m_ptr = 0; m_own = 0;
    rst = 1'b1;
  endtask
  task automatic test_reset();
    int at, t0;
    rst = 1'b0;
    req = 2'b11;
    dat = {16'($urandom), 32'($urandom)};
    repeat (3) tick();
    n_chk++; if (s_ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %0h expected 0", s_ack); end
    n_chk++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h expected 0", s_err); end
    n_chk++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", s_busy); end
    n_chk++; if (s_own !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %0h expected 0", s_own); end
    n_chk++; if (s_start !== 1'b0 || sq.size() !== 0) begin n_fail++; $display("FAIL reset_start: got %0h expected 0", s_start); end
    n_chk++; if (s_dat !== 24'h0) begin n_fail++; $display("FAIL reset_dat: got %0h expected 0", s_dat); end
    sq.delete(); aq.delete(); m_ptr = 0;
    rst = 1'b1;
    t0 = t;
    wait_start(10, at);
    n_chk++; if (at !== t0 + 1) begin n_fail++; $display("FAIL reset_first_start: got %0d expected %0d", at, t0 + 1); end
    n_chk++; if (s_own !== 1'b0) begin n_fail++; $display("FAIL reset_first_owner: got %0d expected 0", s_own); end
  endtask
  task automatic test_single();
    int s, a, t0;
    reset_dut();
    dat[W-1:0] = make_cmd(7'h00, 9'h097);
    req = 2'b01;
    t0 = t;
    wait_start(10, s);
    n_chk++; if (s !== t0 + 1) begin n_fail++; $display("FAIL single_start_lat: got %0d expected %0d", s, t0 + 1); end
    n_chk++; if (s_dat !== 24'h340097) begin n_fail++; $display("FAIL single_dat: got %0h expected 340097", s_dat); end
    n_chk++; if (s_own !== 1'b0) begin n_fail++; $display("FAIL single_owner: got %0d expected 0", s_own); end
    wait_ack(100, a);
    n_chk++; if (a !== s + busy_len + 2) begin n_fail++; $display("FAIL single_ack_time: got %0d expected %0d", a, s + busy_len + 2); end
    n_chk++; if (a !== rise_t + 1) begin n_fail++; $display("FAIL single_ack_after_done: got %0d expected %0d", a, rise_t + 1); end
    n_chk++; if (s_ack !== 2'b01 || s_err !== 1'b0) begin n_fail++; $display("FAIL single_ack: got %0h/%0h expected 1/0", s_ack, s_err); end
    n_chk++; if (s_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_in_ack: got %0h expected 1", s_busy); end
    tick();
    n_chk++; if (s_ack !== 2'b00 || s_busy !== 1'b0) begin n_fail++; $display("FAIL single_after_ack: got ack %0h busy %0h expected 0 0", s_ack, s_busy); end
  endtask
  task automatic test_simultaneous();
    reset_dut();
    busy_len = 5;
    dat = {16'($urandom), 32'($urandom)};
    req = 2'b11;
    for (int i = 0; i < 200 && aq.size() < 2; i++) tick();
    n_chk++; if (sq.size() !== 2 || aq.size() !== 2) begin n_fail++; $display("FAIL simul_count: got %0d/%0d expected 2/2", sq.size(), aq.size()); end
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (sq[i].own !== i || sq[i].own !== sq[i].exp_own) begin n_fail++; $display("FAIL simul_owner%0d: got %0d expected %0d", i, sq[i].own, i); end
      n_chk++; if (sq[i].d !== sq[i].exp_d) begin n_fail++; $display("FAIL simul_dat%0d: got %0h expected %0h", i, sq[i].d, sq[i].exp_d); end
      n_chk++; if (aq[i].a !== N'(1 << i) || aq[i].e !== 1'b0) begin n_fail++; $display("FAIL simul_ack%0d: got %0h expected %0h", i, aq[i].a, 1 << i); end
    end
    n_chk++; if (sq[1].t !== aq[0].t + 2) begin n_fail++; $display("FAIL simul_gap: got %0d expected %0d", sq[1].t, aq[0].t + 2); end
  endtask
  task automatic test_alternate();
    reset_dut();
    busy_len = 8;
    dat = {16'($urandom), 32'($urandom)};
    rereq = 2'b11;
    req = 2'b11;
    for (int i = 0; i < 400 && aq.size() < 4; i++) tick();
    rereq = '0;
    n_chk++; if (aq.size() !== 4) begin n_fail++; $display("FAIL alt_count: got %0d expected 4", aq.size()); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (sq[i].own !== i % 2 || aq[i].a !== N'(1 << (i % 2))) begin n_fail++; $display("FAIL alt_order%0d: got %0d/%0h expected %0d", i, sq[i].own, aq[i].a, i % 2); end
    end
  endtask
  task automatic test_timeout();
    int s, a;
    reset_dut();
    hang = 1;
    dat = {16'($urandom), 32'($urandom)};
    req = 2'b01;
    wait_start(10, s);
    wait_ack(200, a);
    n_chk++; if (a !== s + 1 + TO) begin n_fail++; $display("FAIL timeout_time: got %0d expected %0d", a, s + 1 + TO); end
    n_chk++; if (s_ack !== 2'b01 || s_err !== 1'b1) begin n_fail++; $display("FAIL timeout_ack: got %0h/%0h expected 1/1", s_ack, s_err); end
    tick();
    n_chk++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear: got %0h expected 0", s_err); end
    hang = 0; kick = 1;
    tick();
    kick = 0;
    busy_len = 10;
    req[1] = 1'b1;
    wait_start(10, s);
    n_chk++; if (s_own !== 1'b1 || sq[$].exp_own !== 1) begin n_fail++; $display("FAIL timeout_next_owner: got %0d expected 1", s_own); end
    wait_ack(100, a);
    n_chk++; if (s_ack !== 2'b10 || s_err !== 1'b0) begin n_fail++; $display("FAIL timeout_next_ack: got %0h/%0h expected 2/0", s_ack, s_err); end
  endtask
  task automatic test_reset_mid();
    int s, a, n;
    reset_dut();
    dat = {16'($urandom), 32'($urandom)};
    busy_len = 4;
    req = 2'b01;
    wait_ack(100, a);
    tick();
    busy_len = 30;
    req = 2'b10;
    wait_start(10, s);
    repeat (10) tick();
    n = aq.size();
    rst = 1'b0;
    #1;
    n_chk++; if (ack !== 2'b00 || err !== 1'b0 || start !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pulses: got %0h %0h %0h expected 0", ack, err, start); end
    n_chk++; if (busy !== 1'b0 || owner !== 1'b0 || odat !== 24'h0) begin n_fail++; $display("FAIL mid_reset_state: got %0h %0h %0h expected 0", busy, owner, odat); end
    repeat (2) tick();
    m_ptr = 0;
    req = 2'b11;
    rst = 1'b1;
    wait_start(10, s);
    n_chk++; if (aq.size() !== n) begin n_fail++; $display("FAIL mid_reset_no_ack: got %0d acks expected %0d", aq.size(), n); end
    n_chk++; if (s_own !== 1'b0 || sq[$].exp_own !== 0) begin n_fail++; $display("FAIL mid_reset_ptr: got %0d expected 0", s_own); end
    n_chk++; if (s_dat !== sq[$].exp_d) begin n_fail++; $display("FAIL mid_reset_dat: got %0h expected %0h", s_dat, sq[$].exp_d); end
  endtask
  task automatic test_back_to_back();
    int s, a, n;
    reset_dut();
    busy_len = 20;
    dat = {16'($urandom), 32'($urandom)};
    req = 2'b01;
    wait_start(10, s);
    repeat (5) tick();
    req[1] = 1'b1;
    n = sq.size();
    wait_ack(100, a);
    n_chk++; if (sq.size() !== n) begin n_fail++; $display("FAIL pend_no_start: got %0d starts expected %0d", sq.size(), n); end
    n_chk++; if (s_ack !== 2'b01) begin n_fail++; $display("FAIL pend_first_ack: got %0h expected 1", s_ack); end
    wait_start(10, s);
    n_chk++; if (s !== a + 2) begin n_fail++; $display("FAIL pend_start_time: got %0d expected %0d", s, a + 2); end
    n_chk++; if (s_own !== 1'b1 || s_dat !== dat[W +: W]) begin n_fail++; $display("FAIL pend_owner: got %0d/%0h expected 1/%0h", s_own, s_dat, dat[W +: W]); end
  endtask
  task automatic test_random();
    int n_raised = 0, k;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      if (i < 2000 && n_raised < 24 && $urandom_range(0, 7) == 0) begin
        k = int'($urandom_range(0, N - 1));
        if (!req[k]) begin
          dat[k*W +: W] = W'($urandom);
          req[k] = 1'b1;
          n_raised++;
        end
      end
      tick();
      if (s_start) busy_len = int'($urandom_range(1, 40));
    end
    n_chk++; if (sq.size() !== n_raised || aq.size() !== n_raised) begin n_fail++; $display("FAIL rand_count: got %0d/%0d expected %0d", sq.size(), aq.size(), n_raised); end
    foreach (sq[i]) begin
      n_chk++; if (sq[i].own !== sq[i].exp_own || sq[i].d !== sq[i].exp_d) begin n_fail++; $display("FAIL rand_grant%0d: got %0d/%0h expected %0d/%0h", i, sq[i].own, sq[i].d, sq[i].exp_own, sq[i].exp_d); end
    end
    foreach (aq[i]) begin
      n_chk++; if (aq[i].a !== N'(1 << aq[i].exp_own) || aq[i].e !== 1'b0) begin n_fail++; $display("FAIL rand_ack%0d: got %0h/%0h expected %0h/0", i, aq[i].a, aq[i].e, 1 << aq[i].exp_own); end
    end
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_alternate();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
